// File: rtl/ddc_retune_controller.sv
// Retune sequencer for the downconverter DDS: takes a new phase increment, loads it
// immediately or on a sync strobe, then blanks the I/Q stream until old-frequency samples flush.
module ddc_retune_controller #(
  parameter int WIDTH         = 16,
  parameter int FLUSH_SAMPLES = 64,
  parameter int SYNC_TIMEOUT  = 4096
) (
  input  logic                    i_clock,
  input  logic                    i_reset_n,
  input  logic [31:0]             i_cfg_phase_inc,
  input  logic                    i_cfg_at_sync,
  input  logic                    i_cfg_valid,
  output logic                    o_cfg_ready,
  input  logic                    i_sync,
  output logic [31:0]             o_phase_inc,
  output logic                    o_phase_inc_valid,
  input  logic signed [WIDTH-1:0] i_inph_data,
  input  logic signed [WIDTH-1:0] i_quad_data,
  input  logic                    i_valid,
  output logic signed [WIDTH-1:0] o_inph_data,
  output logic signed [WIDTH-1:0] o_quad_data,
  output logic                    o_valid,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_sync_timeout,
  output logic [31:0]             o_active_phase_inc
);

  localparam int WAIT_W = (SYNC_TIMEOUT > 0) ? $clog2(SYNC_TIMEOUT + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SYNC_TIMEOUT - 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = '1;
  localparam logic [15:0]       FLUSH_LAST = 16'(FLUSH_SAMPLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_APPLY = 2'd2,
    S_FLUSH = 2'd3
  } state_t;

  state_t                  r_state;
  logic [31:0]             r_phase_inc;
  logic                    r_phase_inc_valid;
  logic [31:0]             r_active_phase_inc;
  logic                    r_done;
  logic                    r_sync_timeout;
  logic [WAIT_W-1:0]       r_wait_cnt;
  logic [15:0]             r_flush_cnt;
  logic signed [WIDTH-1:0] r_inph_p1;
  logic signed [WIDTH-1:0] r_quad_p1;
  logic                    r_vld_p1;

  logic w_ready;
  logic w_accept;
  logic w_mute;
  logic w_timeout_hit;
  logic w_last_beat;

  assign w_ready       = (r_state == S_IDLE) && i_reset_n;
  assign w_accept      = w_ready && i_cfg_valid;
  assign w_mute        = (r_state == S_APPLY) || (r_state == S_FLUSH);
  // A strobe in the same cycle as the timeout takes priority, so the timeout is only
  // considered when i_sync is low.
  assign w_timeout_hit = (SYNC_TIMEOUT != 0) && (r_wait_cnt == WAIT_LAST) && !i_sync;
  assign w_last_beat   = i_valid && (r_flush_cnt == FLUSH_LAST);

  // Control FSM with registered pulse outputs
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      r_state            <= S_IDLE;
      r_phase_inc        <= '0;
      r_phase_inc_valid  <= 1'b0;
      r_active_phase_inc <= '0;
      r_done             <= 1'b0;
      r_sync_timeout     <= 1'b0;
      r_wait_cnt         <= '0;
      r_flush_cnt        <= '0;
    end else begin
      r_phase_inc_valid <= 1'b0;
      r_done            <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_phase_inc <= i_cfg_phase_inc;
            r_wait_cnt  <= '0;
            if (i_cfg_at_sync) begin
              r_state <= S_ARMED;
            end else begin
              r_state            <= S_APPLY;
              r_phase_inc_valid  <= 1'b1;
              r_active_phase_inc <= i_cfg_phase_inc;
            end
          end
        end
        S_ARMED: begin
          if (i_sync || w_timeout_hit) begin
            r_state            <= S_APPLY;
            r_phase_inc_valid  <= 1'b1;
            r_active_phase_inc <= r_phase_inc;
            if (w_timeout_hit) begin
              r_sync_timeout <= 1'b1;
            end
          end
          if (r_wait_cnt != WAIT_MAX) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end
        S_APPLY: begin
          r_state     <= S_FLUSH;
          r_flush_cnt <= '0;
        end
        S_FLUSH: begin
          if (w_last_beat) begin
            r_state     <= S_IDLE;
            r_done      <= 1'b1;
            r_flush_cnt <= '0;
          end else if (i_valid) begin
            r_flush_cnt <= r_flush_cnt + 16'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Stage p1: registered pass-through with valid gating while muted
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      r_inph_p1 <= '0;
      r_quad_p1 <= '0;
      r_vld_p1  <= 1'b0;
    end else begin
      r_inph_p1 <= i_inph_data;
      r_quad_p1 <= i_quad_data;
      r_vld_p1  <= i_valid && !w_mute;
    end
  end

  assign o_cfg_ready        = w_ready;
  assign o_phase_inc        = r_phase_inc;
  assign o_phase_inc_valid  = r_phase_inc_valid;
  assign o_active_phase_inc = r_active_phase_inc;
  assign o_busy             = (r_state != S_IDLE);
  assign o_done             = r_done;
  assign o_sync_timeout     = r_sync_timeout;
  assign o_inph_data        = r_inph_p1;
  assign o_quad_data        = r_quad_p1;
  assign o_valid            = r_vld_p1;

endmodule
